// File: rtl/vga_write_arbiter_if.sv
// Pixel-write bus between the drawing engines and the VGA write arbiter.
// The master side is the set of pixel sources; the slave side is the arbiter.
interface vga_write_arbiter_if #(
   parameter int N  = 3,
   parameter int XW = 11,
   parameter int YW = 11
);
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*XW-1:0] x_in;
   logic [N*YW-1:0] y_in;
   logic [N-1:0]    color_in;
   logic [N-1:0]    grant;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            color;
   logic            plot;
   logic [2:0]      owner;
   logic            locked;

   modport master (
      output req, lock, x_in, y_in, color_in,
      input  grant, x, y, color, plot, owner, locked
   );

   modport slave (
      input  req, lock, x_in, y_in, color_in,
      output grant, x, y, color, plot, owner, locked
   );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for the shared VGA pixel-write port, with a burst lock
// so a tile redraw runs uninterrupted and a watchdog that bounds any lock.
module vga_write_arbiter #(
   parameter int N        = 3,
   parameter int XW       = 11,
   parameter int YW       = 11,
   parameter int HOLD_MAX = 4096
) (
   input logic               clk,
   input logic               reset,
   vga_write_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner_idx;
   logic [CW-1:0] hold_cnt;
   logic          win_valid;
   logic [IW-1:0] win_idx;
   logic [N-1:0]  grant_c;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          color_q;
   logic          plot_q;

   function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   function automatic logic [IW-1:0] succ(input logic [IW-1:0] i);
      return (int'(i) == N - 1) ? '0 : i + IW'(1);
   endfunction

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      grant_c   = '0;
      if (state == ST_ARB) begin
         for (int k = 0; k < N; k++) begin
            if (!win_valid && bus.req[rr_slot(rr_ptr, k)]) begin
               win_valid = 1'b1;
               win_idx   = rr_slot(rr_ptr, k);
            end
         end
      end else if (hold_cnt != HOLD_LIM && bus.req[owner_idx]) begin
         // The watchdog cycle grants nobody, even if the owner is requesting.
         win_valid = 1'b1;
         win_idx   = owner_idx;
      end
      if (win_valid) grant_c[win_idx] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_ARB;
         rr_ptr    <= '0;
         owner_idx <= '0;
         hold_cnt  <= '0;
         x_q       <= '0;
         y_q       <= '0;
         color_q   <= 1'b0;
         plot_q    <= 1'b0;
      end else begin
         plot_q <= win_valid;
         if (win_valid) begin
            x_q     <= bus.x_in[win_idx*XW +: XW];
            y_q     <= bus.y_in[win_idx*YW +: YW];
            color_q <= bus.color_in[win_idx];
         end
         case (state)
            ST_ARB: begin
               if (win_valid) begin
                  owner_idx <= win_idx;
                  if (bus.lock[win_idx]) begin
                     state    <= ST_HOLD;
                     hold_cnt <= CW'(1);
                  end else begin
                     rr_ptr <= succ(win_idx);
                  end
               end
            end
            default: begin
               // Lock dropped (last pixel or idle release) or watchdog expiry.
               if (hold_cnt == HOLD_LIM || !bus.lock[owner_idx]) begin
                  state    <= ST_ARB;
                  rr_ptr   <= succ(owner_idx);
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign bus.grant  = grant_c;
   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.color  = color_q;
   assign bus.plot   = plot_q;
   assign bus.owner  = 3'(owner_idx);
   assign bus.locked = (state == ST_HOLD);
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: grant/locked checked per cycle by the
// stimulus, accepted pixels checked by a monitor against a scoreboard queue.
module tb_vga_write_arbiter;
   localparam int N = 3, XW = 11, YW = 11, HOLD_MAX = 8;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          c;
   } pix_t;

   logic clk = 1'b0;
   logic reset;
   logic [N-1:0]  req, lock;
   logic [XW-1:0] sx [N];
   logic [YW-1:0] sy [N];
   logic [N-1:0]  sc;
   pix_t exp_q [$];
   int checks = 0;
   int failures = 0;

   vga_write_arbiter_if #(.N(N), .XW(XW), .YW(YW)) bus ();

   vga_write_arbiter #(.N(N), .XW(XW), .YW(YW), .HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.req      = req;
   assign bus.lock     = lock;
   assign bus.x_in     = {sx[2], sx[1], sx[0]};
   assign bus.y_in     = {sy[2], sy[1], sy[0]};
   assign bus.color_in = sc;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: inputs already set; check grant/locked mid-cycle, record accepted pixel.
   task automatic step(input logic [N-1:0] exp_grant, input logic exp_locked, input string name);
      @(negedge clk);
      check({name, " grant"}, 32'(bus.grant), 32'(exp_grant));
      check({name, " locked"}, 32'(bus.locked), 32'(exp_locked));
      for (int i = 0; i < N; i++)
         if (exp_grant[i]) exp_q.push_back('{x: sx[i], y: sy[i], c: sc[i]});
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every plot must match the oldest expected pixel.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.plot === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected plot", 32'd1, 32'd0);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               check("pixel", 32'({bus.x, bus.y, bus.color}), 32'(e));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      sc    = '0;
      for (int i = 0; i < N; i++) begin
         sx[i] = '0;
         sy[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset grant", 32'(bus.grant), 32'd0);
      check("reset plot", 32'(bus.plot), 32'd0);
      check("reset owner", 32'(bus.owner), 32'd0);
      check("reset locked", 32'(bus.locked), 32'd0);
      check("reset xy", 32'({bus.x, bus.y, bus.color}), 32'd0);
      reset = 1'b0;

      // Single source, one pixel.
      sx[1] = 11'd100; sy[1] = 11'd30; sc[1] = 1'b1;
      req = 3'b010;
      step(3'b010, 1'b0, "t1");
      req = 3'b000;
      step(3'b000, 1'b0, "t1 idle");

      // Two sources, no lock: alternate 0,2,0,2 with wrap.
      pulse_reset();
      sx[0] = 11'd10;  sy[0] = 11'd20;  sc[0] = 1'b0;
      sx[2] = 11'd500; sy[2] = 11'd600; sc[2] = 1'b1;
      req = 3'b101;
      for (int i = 0; i < 3; i++) begin
         step(3'b001, 1'b0, "t2 src0");
         step(3'b100, 1'b0, "t2 src2");
      end
      check("t2 owner", 32'(bus.owner), 32'd2);

      // src0 once to move the pointer to 1, then a locked src1 burst.
      req = 3'b001;
      step(3'b001, 1'b0, "t3 pre");
      req = 3'b011;
      sy[1] = 11'd40; sc[1] = 1'b0;
      sx[1] = 11'd200; lock = 3'b010; step(3'b010, 1'b0, "t3 b0");
      sx[1] = 11'd201; lock = 3'b010; step(3'b010, 1'b1, "t3 b1");
      sx[1] = 11'd202; lock = 3'b010; step(3'b010, 1'b1, "t3 b2");
      sx[1] = 11'd203; lock = 3'b000; step(3'b010, 1'b1, "t3 b3");
      req = 3'b001;
      step(3'b001, 1'b0, "t3 src0");

      // Watchdog: src2 locks, then stalls with lock held; src0 waits.
      sx[2] = 11'd7; sy[2] = 11'd9; sc[2] = 1'b0;
      req = 3'b101; lock = 3'b100;
      step(3'b100, 1'b0, "t4 enter");
      req = 3'b001;
      for (int i = 0; i < HOLD_MAX; i++) step(3'b000, 1'b1, "t4 stall");
      check("t4 owner held", 32'(bus.owner), 32'd2);
      step(3'b001, 1'b0, "t4 src0");
      check("t4 owner", 32'(bus.owner), 32'd0);
      req = 3'b000; lock = 3'b000;

      // Reset in the middle of a hold.
      req = 3'b100; lock = 3'b100;
      step(3'b100, 1'b0, "t5 enter");
      req = 3'b000;
      step(3'b000, 1'b1, "t5 stall");
      step(3'b000, 1'b1, "t5 stall");
      pulse_reset();
      check("t5 grant", 32'(bus.grant), 32'd0);
      check("t5 plot", 32'(bus.plot), 32'd0);
      check("t5 locked", 32'(bus.locked), 32'd0);
      check("t5 owner", 32'(bus.owner), 32'd0);
      lock = 3'b000; req = 3'b101;
      step(3'b001, 1'b0, "t5 src0");
      req = 3'b000;

      // Idle: nothing plotted, pointer unchanged (stays at 1).
      for (int i = 0; i < 20; i++) begin
         step(3'b000, 1'b0, "t6 idle");
         if (i > 0) check("t6 plot", 32'(bus.plot), 32'd0);
      end
      req = 3'b101;
      step(3'b100, 1'b0, "t6 after idle");
      req = 3'b000;

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
